// File: rtl/reset_pkg.sv
// Shared definitions for the board reset sequencer.
//   CAUSE_*     : encodings of the sticky reset-cause field
//   seq_state_t : sequencer FSM states
package reset_pkg;

    localparam logic [1:0] CAUSE_POR = 2'b00;
    localparam logic [1:0] CAUSE_BTN = 2'b01;
    localparam logic [1:0] CAUSE_SW  = 2'b10;

    typedef enum logic [1:0] {
        ASSERT  = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } seq_state_t;

endpackage

// File: rtl/button_debounce.sv
// Synchroniser plus debouncer for an asynchronous, bouncy, active-low button.
// Ports:
//   clk      : system clock
//   reset_n  : asynchronous active-low reset (debounced level resets to 1 = released)
//   button_n : raw button input, asynchronous
//   level_n  : debounced, synchronised active-low level
module button_debounce #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset_n,
    input  logic button_n,
    output logic level_n
);

    localparam int unsigned   DW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic                   level_q;
    logic [DW-1:0]          cnt_q;

    assign synced  = sync_q[SYNC_STAGES-1];
    assign level_n = level_q;

    // The counter tracks how long the synchronised input has disagreed with
    // the current debounced level; any agreement restarts the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '1;
            level_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], button_n};
            if (synced == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == DB_LAST) begin
                level_q <= synced;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + DW'(1);
            end
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Board-level reset generator: holds all resets asserted, then releases them
// one at a time, lowest index first. Records the cause of the last reset.
// Ports:
//   clk          : system clock
//   reset_n      : asynchronous active-low reset (power-on)
//   button_n     : raw active-low push-button
//   sw_reset_req : single-cycle software reset pulse
//   cause_clr    : pulse returning reset_cause to POR
//   rst_out_n    : sequenced active-low reset outputs, bit 0 released first
//   busy         : high while any rst_out_n bit is low
//   reset_cause  : 00 POR, 01 button, 10 software
module reset_sequencer
    import reset_pkg::*;
#(
    parameter int unsigned NUM_OUT         = 3,
    parameter int unsigned HOLD_CYCLES     = 63,
    parameter int unsigned STAGGER_CYCLES  = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 1024,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               button_n,
    input  logic               sw_reset_req,
    input  logic               cause_clr,
    output logic [NUM_OUT-1:0] rst_out_n,
    output logic               busy,
    output logic [1:0]         reset_cause
);

    localparam int unsigned CMAX = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
    localparam int unsigned CW   = $clog2(CMAX + 1);
    localparam int unsigned IW   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] STAG_LAST = CW'(STAGGER_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_OUT - 1);

    seq_state_t         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [NUM_OUT-1:0] rst_q, rst_d;
    logic [1:0]         cause_q, cause_d;
    logic               busy_q;
    logic               btn_level_n;
    logic               btn_req;
    logic               req;

    button_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_button_debounce (
        .clk     (clk),
        .reset_n (reset_n),
        .button_n(button_n),
        .level_n (btn_level_n)
    );

    assign btn_req = ~btn_level_n;
    assign req     = btn_req | sw_reset_req;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ASSERT;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_q   <= '0;
            cause_q <= CAUSE_POR;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
            cause_q <= cause_d;
            // busy is registered from the next output value so it falls on
            // the same edge as the last release.
            busy_q  <= ~(&rst_d);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rst_d   = rst_q;
        cause_d = cause_q;

        if (btn_req) begin
            cause_d = CAUSE_BTN;
        end else if (sw_reset_req) begin
            cause_d = CAUSE_SW;
        end else if (cause_clr) begin
            cause_d = CAUSE_POR;
        end

        if (req) begin
            state_d = ASSERT;
            cnt_d   = '0;
            idx_d   = '0;
            rst_d   = '0;
        end else begin
            case (state_q)
                ASSERT: begin
                    rst_d = '0;
                    if (cnt_q == HOLD_LAST) begin
                        cnt_d = '0;
                        if (NUM_OUT == 1) begin
                            state_d = RUN;
                            rst_d   = '1;
                        end else begin
                            state_d  = RELEASE;
                            rst_d[0] = 1'b1;
                            idx_d    = IW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                RELEASE: begin
                    if (cnt_q == STAG_LAST) begin
                        cnt_d = '0;
                        for (int unsigned i = 0; i < NUM_OUT; i++) begin
                            if (IW'(i) == idx_q) begin
                                rst_d[i] = 1'b1;
                            end
                        end
                        if (idx_q == IDX_LAST) begin
                            state_d = RUN;
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                RUN: begin
                    rst_d = '1;
                end
                default: begin
                    state_d = ASSERT;
                    cnt_d   = '0;
                    rst_d   = '0;
                end
            endcase
        end
    end

    assign rst_out_n   = rst_q;
    assign busy        = busy_q;
    assign reset_cause = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer. The reference model tracks edges
// since the last request and derives the number of released outputs from
// that with plain arithmetic.
module tb_reset_sequencer;

    localparam int N     = 3;
    localparam int HOLD  = 8;
    localparam int STAG  = 4;
    localparam int DEB   = 16;
    localparam int SYNC  = 2;

    logic         clk;
    logic         reset_n;
    logic         button_n;
    logic         sw_reset_req;
    logic         cause_clr;
    logic [N-1:0] rst_out_n;
    logic         busy;
    logic [1:0]   reset_cause;

    int checks   = 0;
    int failures = 0;

    // reference model state
    int         since;
    int         run;
    logic       deb_m;
    logic [1:0] cause_m;
    logic       sh [SYNC];

    reset_sequencer #(
        .NUM_OUT        (N),
        .HOLD_CYCLES    (HOLD),
        .STAGGER_CYCLES (STAG),
        .DEBOUNCE_CYCLES(DEB),
        .SYNC_STAGES    (SYNC)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .button_n    (button_n),
        .sw_reset_req(sw_reset_req),
        .cause_clr   (cause_clr),
        .rst_out_n   (rst_out_n),
        .busy        (busy),
        .reset_cause (reset_cause)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        since   = 0;
        run     = 0;
        deb_m   = 1'b1;
        cause_m = 2'b00;
        for (int i = 0; i < SYNC; i++) sh[i] = 1'b1;
    endtask

    task automatic check_outputs();
        int           k;
        logic [N-1:0] exp_rst;
        k = (since >= HOLD) ? 1 + (since - HOLD) / STAG : 0;
        if (k > N) k = N;
        exp_rst = N'((1 << k) - 1);
        check("rst_out_n", 8'(rst_out_n), 8'(exp_rst));
        check("busy", 8'(busy), 8'(k < N));
        check("reset_cause", 8'(reset_cause), 8'(cause_m));
    endtask

    // One clock edge: update the model from the inputs seen at the edge,
    // then compare shortly after the edge.
    task automatic tick();
        logic s;
        logic btn;
        @(posedge clk);
        s   = sh[SYNC-1];
        btn = (deb_m == 1'b0);
        if (btn || sw_reset_req) begin
            since   = 0;
            cause_m = btn ? 2'b01 : 2'b10;
        end else begin
            if (since < 100000) since++;
            if (cause_clr) cause_m = 2'b00;
        end
        if (s != deb_m) begin
            run++;
            if (run == DEB) begin
                deb_m = s;
                run   = 0;
            end
        end else begin
            run = 0;
        end
        for (int i = SYNC - 1; i > 0; i--) sh[i] = sh[i-1];
        sh[0] = button_n;
        #1;
        check_outputs();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic sw_pulse();
        sw_reset_req = 1'b1;
        tick();
        sw_reset_req = 1'b0;
    endtask

    initial begin
        int btn_left;

        button_n     = 1'b1;
        sw_reset_req = 1'b0;
        cause_clr    = 1'b0;
        reset_n      = 1'b1;
        #1 reset_n   = 1'b0;
        model_reset();
        #2;
        check("por_rst", 8'(rst_out_n), 8'h00);
        check("por_busy", 8'(busy), 8'h01);
        check("por_cause", 8'(reset_cause), 8'h00);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // power-on sequence
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (e == 7)  check("por_e7", 8'(rst_out_n), 8'h00);
            if (e == 8)  check("por_e8", 8'(rst_out_n), 8'h01);
            if (e == 12) check("por_e12", 8'(rst_out_n), 8'h03);
            if (e == 15) check("por_e15_busy", 8'(busy), 8'h01);
            if (e == 16) check("por_e16", 8'({busy, rst_out_n}), 8'h07);
        end

        // short bounce is rejected
        button_n = 1'b0;
        ticks(10);
        button_n = 1'b1;
        ticks(30);
        check("bounce_run", 8'(rst_out_n), 8'h07);

        // long press: outputs drop at edge SYNC+DEB+1 after the fall
        button_n = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (i == 18) check("press_e18", 8'(rst_out_n), 8'h07);
            if (i == 19) check("press_e19", 8'({reset_cause, 1'b0, rst_out_n}), 8'h10);
        end
        check("press_held", 8'(rst_out_n), 8'h00);
        button_n = 1'b1;
        ticks(45);
        check("press_rel", 8'(rst_out_n), 8'h07);

        // software reset from RUN
        sw_pulse();
        check("sw_run", 8'({reset_cause, 1'b0, rst_out_n}), 8'h20);
        ticks(20);

        // software reset mid-release
        sw_pulse();
        ticks(8);
        check("mid_rel_001", 8'(rst_out_n), 8'h01);
        sw_pulse();
        check("mid_rel_000", 8'(rst_out_n), 8'h00);
        ticks(7);
        check("mid_rel_e7", 8'(rst_out_n), 8'h00);
        tick();
        check("mid_rel_e8", 8'(rst_out_n), 8'h01);
        ticks(10);

        // asynchronous reset while 011
        sw_pulse();
        ticks(12);
        check("pre_async", 8'(rst_out_n), 8'h03);
        reset_n = 1'b0;
        #1;
        model_reset();
        check("async_rst", 8'(rst_out_n), 8'h00);
        check("async_busy", 8'(busy), 8'h01);
        check("async_cause", 8'(reset_cause), 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        ticks(20);

        // button and software together, with cause_clr: button wins
        button_n = 1'b0;
        ticks(25);
        sw_reset_req = 1'b1;
        cause_clr    = 1'b1;
        tick();
        sw_reset_req = 1'b0;
        cause_clr    = 1'b0;
        check("both_cause", 8'(reset_cause), 8'h01);
        button_n = 1'b1;
        ticks(45);
        cause_clr = 1'b1;
        tick();
        cause_clr = 1'b0;
        check("clr_cause", 8'(reset_cause), 8'h00);

        // randomized traffic
        btn_left = 0;
        for (int c = 0; c < 600; c++) begin
            if (btn_left == 0) begin
                button_n = 1'($urandom_range(0, 1));
                btn_left = $urandom_range(1, 40);
            end
            btn_left--;
            sw_reset_req = ($urandom_range(0, 39) == 0);
            cause_clr    = ($urandom_range(0, 29) == 0);
            tick();
        end
        button_n     = 1'b1;
        sw_reset_req = 1'b0;
        cause_clr    = 1'b0;
        ticks(50);
        check("final_run", 8'({busy, rst_out_n}), 8'h07);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
